// File: rtl/register_bank_pkg.sv
// Shared types, index helpers and constants for the parametrised register bank
// and its pending-operand scoreboard.
package register_bank_pkg;

    typedef logic [4:0] regind_t;

    localparam int REG_W_DEFAULT = 32;
    typedef logic [REG_W_DEFAULT-1:0] regval_t;

    // Flags occupy the low nibble of the Flags register.
    localparam int FLAG_LSB  = 0;
    localparam int FLAG_BITS = 4;

    localparam regval_t REG_ZERO = '0;

    function automatic regind_t flags_index(input int nr);
        return regind_t'(nr - 1);
    endfunction

    function automatic regind_t pc_index(input int nr);
        return regind_t'(nr - 2);
    endfunction

    // Register 0, PC and out-of-range indices never hold state of their own.
    function automatic logic is_writable(input regind_t idx, input int nr);
        return (idx != '0) && (idx != pc_index(nr)) && (int'(idx) < nr);
    endfunction

endpackage

// File: rtl/register_bank_scoreboard.sv
// Per-register pending bits set by decode reservations and cleared by commits,
// plus the combined hold toward decode/read.
module register_bank_scoreboard
    import register_bank_pkg::*;
#(
    parameter int NR    = 32,
    parameter int NREAD = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rsv_valid,
    input  regind_t               rsv_index,
    input  logic                  rsv_pair,
    input  logic                  wr_we,
    input  regind_t               wr_index,
    input  logic                  up_we,
    input  regind_t               up_index,
    input  regind_t [NREAD-1:0]   rd_index,
    input  logic    [NREAD-1:0]   bypass_hit,
    output logic                  hold,
    output logic    [NR-1:0]      pending
);

    regind_t rsv_up_index;
    logic    rsv_we;
    logic    rsv_up_we;

    assign rsv_up_index = rsv_index + 5'd1;
    assign rsv_we       = rsv_valid && is_writable(rsv_index, NR);
    assign rsv_up_we    = rsv_valid && rsv_pair && is_writable(rsv_up_index, NR);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                // A reservation in the same cycle belongs to a newer producer, so set beats clear.
                if ((rsv_we && rsv_index == regind_t'(i)) || (rsv_up_we && rsv_up_index == regind_t'(i)))
                    pending[i] <= 1'b1;
                else if ((wr_we && wr_index == regind_t'(i)) || (up_we && up_index == regind_t'(i)))
                    pending[i] <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        hold = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            for (int i = 0; i < NR; i++) begin
                if (rd_index[p] == regind_t'(i) && pending[i] && !bypass_hit[p])
                    hold = 1'b1;
            end
        end
        if (reset)
            hold = 1'b0;
    end

endmodule

// File: rtl/register_bank.sv
// Architectural register file: NREAD combinational read ports, one paired write port,
// a flags write and a pending scoreboard. Forwarding is enabled by REGISTER_BANK_BYPASS_EN.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int NR    = 32,
    parameter int NREAD = 3,
    parameter int W     = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic    [W-1:0]               pc,
    input  regind_t [NREAD-1:0]           rd_index,
    output logic    [NREAD-1:0][W-1:0]    rd_value,
    input  logic                          wr_valid,
    input  regind_t                       wr_index,
    input  logic    [W-1:0]               wr_value,
    input  logic                          wr_has_upper,
    input  logic    [W-1:0]               wr_upper,
    input  logic                          fl_valid,
    input  logic    [FLAG_BITS-1:0]       fl_value,
    input  logic                          rsv_valid,
    input  regind_t                       rsv_index,
    input  logic                          rsv_pair,
    output logic                          hold,
    output logic    [NR-1:0]              pending
);

    localparam regind_t FLAGS = flags_index(NR);
    localparam regind_t PC    = pc_index(NR);

    logic [W-1:0]     regs [NR];
    regind_t          up_index;
    logic             wr_we;
    logic             up_we;
    logic             fl_we;
    logic [NREAD-1:0] bypass_hit;

    assign up_index = wr_index + 5'd1;
    assign wr_we    = wr_valid && !reset && is_writable(wr_index, NR);
    assign up_we    = wr_valid && wr_has_upper && !reset && is_writable(up_index, NR);
    // A full-word commit to Flags overrides the nibble update.
    assign fl_we    = fl_valid && !reset
                      && !(wr_we && wr_index == FLAGS) && !(up_we && up_index == FLAGS);

    // NOTE: the array is reset because architectural state must read zero after reset;
    // it is a small flop array, not a RAM macro, so this costs only reset fan-out.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NR; i++)
                regs[i] <= W'(REG_ZERO);
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (fl_we && FLAGS == regind_t'(i))
                    regs[i][FLAG_LSB +: FLAG_BITS] <= fl_value;
                if (up_we && up_index == regind_t'(i))
                    regs[i] <= wr_upper;
                if (wr_we && wr_index == regind_t'(i))
                    regs[i] <= wr_value;
            end
        end
    end

    always_comb begin
        rd_value   = '0;
        bypass_hit = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (rd_index[p] == PC) begin
                rd_value[p] = pc;
            end else if (!reset && is_writable(rd_index[p], NR)) begin
                for (int i = 0; i < NR; i++) begin
                    if (rd_index[p] == regind_t'(i))
                        rd_value[p] = regs[i];
                end
`ifdef REGISTER_BANK_BYPASS_EN
                // Primary is applied last so it wins over the upper value.
                if (up_we && up_index == rd_index[p]) begin
                    rd_value[p]   = wr_upper;
                    bypass_hit[p] = 1'b1;
                end
                if (wr_we && wr_index == rd_index[p]) begin
                    rd_value[p]   = wr_value;
                    bypass_hit[p] = 1'b1;
                end
`endif
            end
        end
    end

    register_bank_scoreboard #(
        .NR    (NR),
        .NREAD (NREAD)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .rsv_valid  (rsv_valid),
        .rsv_index  (rsv_index),
        .rsv_pair   (rsv_pair),
        .wr_we      (wr_we),
        .wr_index   (wr_index),
        .up_we      (up_we),
        .up_index   (up_index),
        .rd_index   (rd_index),
        .bypass_hit (bypass_hit),
        .hold       (hold),
        .pending    (pending)
    );

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank with an array-based reference model and a
// per-cycle compare process; follows REGISTER_BANK_BYPASS_EN like the design.
module tb_register_bank;
    import register_bank_pkg::*;

    localparam int NR    = 32;
    localparam int NREAD = 3;
    localparam int W     = 32;
    localparam int PCI   = NR - 2;
    localparam int FLI   = NR - 1;
`ifdef REGISTER_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                       clock = 1'b0;
    logic                       reset;
    logic    [W-1:0]            pc;
    regind_t [NREAD-1:0]        rd_index;
    logic    [NREAD-1:0][W-1:0] rd_value;
    logic                       wr_valid;
    regind_t                    wr_index;
    logic    [W-1:0]            wr_value;
    logic                       wr_has_upper;
    logic    [W-1:0]            wr_upper;
    logic                       fl_valid;
    logic    [3:0]              fl_value;
    logic                       rsv_valid;
    regind_t                    rsv_index;
    logic                       rsv_pair;
    logic                       hold;
    logic    [NR-1:0]           pending;

    always #5 clock = ~clock;

    register_bank #(.NR(NR), .NREAD(NREAD), .W(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .pc           (pc),
        .rd_index     (rd_index),
        .rd_value     (rd_value),
        .wr_valid     (wr_valid),
        .wr_index     (wr_index),
        .wr_value     (wr_value),
        .wr_has_upper (wr_has_upper),
        .wr_upper     (wr_upper),
        .fl_valid     (fl_valid),
        .fl_value     (fl_value),
        .rsv_valid    (rsv_valid),
        .rsv_index    (rsv_index),
        .rsv_pair     (rsv_pair),
        .hold         (hold),
        .pending      (pending)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: architectural contents and pending flags per register.
    logic [W-1:0] m_regs [NR];
    bit           m_pend [NR];

    function automatic bit legal(input int idx);
        return idx != 0 && idx != PCI && idx < NR;
    endfunction

    function automatic bit fwd_primary(input int idx);
        return BYP && wr_valid && int'(wr_index) == idx;
    endfunction

    function automatic bit fwd_upper(input int idx);
        return BYP && wr_valid && wr_has_upper && ((int'(wr_index) + 1) % 32) == idx;
    endfunction

    function automatic logic [W-1:0] exp_read(input int idx);
        if (idx == PCI)              return pc;
        if (reset || !legal(idx))    return '0;
        if (fwd_primary(idx))        return wr_value;
        if (fwd_upper(idx))          return wr_upper;
        return m_regs[idx];
    endfunction

    function automatic logic exp_hold();
        if (reset) return 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            int idx = int'(rd_index[p]);
            if (legal(idx) && m_pend[idx] && !fwd_primary(idx) && !fwd_upper(idx))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NR-1:0] exp_pending();
        logic [NR-1:0] v = '0;
        for (int i = 0; i < NR; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic void model_step();
        int wi, ui, ri, rj;
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            return;
        end
        if (fl_valid) m_regs[FLI][3:0] = fl_value;
        if (wr_valid) begin
            wi = int'(wr_index);
            ui = (wi + 1) % 32;
            if (legal(wi)) begin
                m_regs[wi] = wr_value;
                m_pend[wi] = 1'b0;
            end
            if (wr_has_upper && legal(ui)) begin
                m_regs[ui] = wr_upper;
                m_pend[ui] = 1'b0;
            end
        end
        if (rsv_valid) begin
            ri = int'(rsv_index);
            rj = (ri + 1) % 32;
            if (legal(ri)) m_pend[ri] = 1'b1;
            if (rsv_pair && legal(rj)) m_pend[rj] = 1'b1;
        end
    endfunction

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int p = 0; p < NREAD; p++)
                check($sformatf("rd_value[%0d] idx %0d", p, rd_index[p]), 64'(rd_value[p]),
                      64'(exp_read(int'(rd_index[p]))));
            check("hold", 64'(hold), 64'(exp_hold()));
            check("pending", 64'(pending), 64'(exp_pending()));
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        wr_valid = 0; wr_index = '0; wr_value = '0; wr_has_upper = 0; wr_upper = '0;
        fl_valid = 0; fl_value = '0; rsv_valid = 0; rsv_index = '0; rsv_pair = 0;
    endtask

    task automatic set_rd(input int a, input int b, input int c);
        rd_index[0] = regind_t'(a);
        rd_index[1] = regind_t'(b);
        rd_index[2] = regind_t'(c);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        pc    = 32'h100;
        set_rd(0, PCI, FLI);
        tick();
        tick();
        reset  = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("reset r0", 64'(rd_value[0]), 64'h0);
        check("reset pc", 64'(rd_value[1]), 64'h100);
        check("reset flags", 64'(rd_value[2]), 64'h0);
        check("reset hold", 64'(hold), 64'h0);
        check("reset pending", 64'(pending), 64'h0);
        for (int i = 0; i < 32; i++) begin
            set_rd(i, 31 - i, PCI);
            tick();
        end

        // Paired write, then a pair whose upper half lands on PC.
        wr_valid = 1; wr_index = 5'd5; wr_value = 32'hDEADBEEF; wr_has_upper = 1; wr_upper = 32'h12345678;
        tick();
        idle();
        set_rd(5, 6, 0);
        #1;
        check("r5 pair", 64'(rd_value[0]), 64'hDEADBEEF);
        check("r6 pair", 64'(rd_value[1]), 64'h12345678);
        wr_valid = 1; wr_index = regind_t'(NR - 3); wr_value = 32'hCAFE0029; wr_has_upper = 1; wr_upper = 32'h0BAD;
        tick();
        idle();
        set_rd(NR - 3, PCI, 0);
        #1;
        check("r29", 64'(rd_value[0]), 64'hCAFE0029);
        check("pc after upper", 64'(rd_value[1]), 64'h100);

        // Reserve r7 then commit it.
        rsv_valid = 1; rsv_index = 5'd7;
        tick();
        idle();
        set_rd(7, 0, 0);
        #1;
        check("hold r7 reserved", 64'(hold), 64'h1);
        wr_valid = 1; wr_index = 5'd7; wr_value = 32'h55;
        #1;
        check("hold r7 commit cycle", 64'(hold), BYP ? 64'h0 : 64'h1);
        check("rd r7 commit cycle", 64'(rd_value[0]), BYP ? 64'h55 : 64'h0);
        tick();
        idle();
        #1;
        check("hold r7 after", 64'(hold), 64'h0);
        check("rd r7 after", 64'(rd_value[0]), 64'h55);

        // Reserve and write r9 together: reservation wins.
        wr_valid = 1; wr_index = 5'd9; wr_value = 32'h99; rsv_valid = 1; rsv_index = 5'd9;
        tick();
        idle();
        set_rd(9, 0, 0);
        #1;
        check("pending9 kept", 64'(pending[9]), 64'h1);
        check("hold r9", 64'(hold), 64'h1);
        wr_valid = 1; wr_index = 5'd9; wr_value = 32'h9A;
        tick();
        idle();
        #1;
        check("pending9 cleared", 64'(pending[9]), 64'h0);
        check("r9 value", 64'(rd_value[0]), 64'h9A);

        // Flags nibble update and full-word priority.
        set_rd(FLI, 0, 0);
        wr_valid = 1; wr_index = regind_t'(FLI); wr_value = 32'hFFFF0000;
        tick();
        idle();
        fl_valid = 1; fl_value = 4'hA;
        tick();
        idle();
        #1;
        check("flags nibble", 64'(rd_value[0]), 64'hFFFF000A);
        fl_valid = 1; fl_value = 4'h5; wr_valid = 1; wr_index = regind_t'(FLI); wr_value = 32'h1;
        tick();
        idle();
        #1;
        check("flags full wins", 64'(rd_value[0]), 64'h1);
        fl_valid = 1; fl_value = 4'hC; wr_valid = 1; wr_index = regind_t'(PCI);
        wr_value = 32'h4444; wr_has_upper = 1; wr_upper = 32'h77;
        tick();
        idle();
        #1;
        check("flags upper wins", 64'(rd_value[0]), 64'h77);

        // Upper write from the last index must not wrap into r0.
        wr_valid = 1; wr_index = 5'd31; wr_value = 32'hABCD; wr_has_upper = 1; wr_upper = 32'h9999;
        tick();
        idle();
        set_rd(31, 0, 0);
        #1;
        check("r31 no wrap", 64'(rd_value[0]), 64'hABCD);
        check("r0 no wrap", 64'(rd_value[1]), 64'h0);

        // Writes and reservations of r0 / PC, then reset mid-stream.
        wr_valid = 1; wr_index = 5'd0; wr_value = 32'h1234; rsv_valid = 1; rsv_index = 5'd0;
        tick();
        idle();
        wr_valid = 1; wr_index = regind_t'(PCI); wr_value = 32'h4444;
        rsv_valid = 1; rsv_index = regind_t'(PCI); rsv_pair = 1;
        tick();
        idle();
        set_rd(0, PCI, FLI);
        #1;
        check("pending r0", 64'(pending[0]), 64'h0);
        check("pending pc", 64'(pending[PCI]), 64'h0);
        check("pending flags pair", 64'(pending[FLI]), 64'h1);
        check("r0 zero", 64'(rd_value[0]), 64'h0);
        check("pc read", 64'(rd_value[1]), 64'h100);
        reset = 1; rsv_valid = 1; rsv_index = 5'd12; wr_valid = 1; wr_index = 5'd12; wr_value = 32'hEEEE;
        set_rd(5, PCI, FLI);
        #1;
        check("rd during reset", 64'(rd_value[0]), 64'h0);
        check("pc during reset", 64'(rd_value[1]), 64'h100);
        check("hold during reset", 64'(hold), 64'h0);
        tick();
        reset = 0;
        idle();
        set_rd(5, 12, FLI);
        #1;
        check("pending after reset", 64'(pending), 64'h0);
        check("r5 after reset", 64'(rd_value[0]), 64'h0);
        check("r12 after reset", 64'(rd_value[1]), 64'h0);
        tick();
        tick();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
